// File: rtl/mem_access_ctrl.sv
// Load/store access controller: turns one execution-unit request into a
// single memory transaction with byte lanes, stalls the pipeline while it is
// in flight, and aborts on misalignment or on a request/response timeout.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_timeout;
  logic               w_misaligned;
  logic [3:0]         w_be;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_accept;
  logic               w_latch_rd;
  logic               w_err_set;
  logic [1:0]         w_err_code;
  logic               w_stall;

  logic               r_err;
  logic [1:0]         r_err_code;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [3:0]         r_be;
  logic [DATA_W-1:0]  r_wdata;

  // Request decode: alignment, byte enables and lane-replicated store data
  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = wdata_i;
    case (size_i)
      2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_misaligned = addr_i[0];
        w_be         = 4'b0011 << addr_i[1:0];
        w_wdata      = {2{wdata_i[15:0]}};
      end
      2'b10: w_misaligned = (addr_i[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == TIMEOUT_C);

  // Next-state and control decode; completion takes priority over timeout
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_latch_rd  = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = r_err_code;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (w_misaligned) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_ALIGN;
          end else begin
            w_accept    = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (mem_gnt_i && (r_we || mem_rvalid_i)) begin
          w_latch_rd  = ~r_we;
          w_state_nxt = ST_DONE;
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_err_code  = ERR_TIMEOUT;
          w_state_nxt = ST_IDLE;
        end else if (mem_gnt_i) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (mem_rvalid_i) begin
          w_latch_rd  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_err_code  = ERR_TIMEOUT;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Timeout counter, cleared on entry to REQ
  always_ff @(posedge clk) begin
    if (!rst_n)                                      r_cnt <= '0;
    else if (w_accept)                               r_cnt <= '0;
    else if (r_state == ST_REQ || r_state == ST_WAIT) r_cnt <= w_cnt_inc;
  end

  // Request latches, load data and error reporting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_rdata    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= '0;
    end else begin
      r_err <= w_err_set;
      if (w_err_set) r_err_code <= w_err_code;
      if (w_latch_rd) r_rdata <= mem_rdata_i;
      if (w_accept) begin
        r_we    <= we_i;
        r_addr  <= {addr_i[ADDR_W-1:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
    end
  end

  assign stall_o     = w_stall;
  assign done_o      = (r_state == ST_DONE);
  assign mem_req_o   = (r_state == ST_REQ);
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign err_code_o  = r_err_code;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected memory
// handshakes, completions and errors; a monitor pops and compares them.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, we_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic [1:0]  err_code_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .we_i(we_i), .size_i(size_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o),
    .rdata_o(rdata_o), .err_o(err_o), .err_code_o(err_code_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_MEM  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  code;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic ev_t mk(logic [1:0] k, logic w, logic [3:0] b,
                             logic [31:0] a, logic [31:0] d, logic [1:0] c);
    ev_t e;
    e.kind = k; e.we = w; e.be = b; e.addr = a; e.data = d; e.code = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, input ev_t act);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event %h with empty scoreboard", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  // Monitor: every observable DUT event must match the next expected entry
  always @(negedge clk) begin
    if (mem_req_o && mem_gnt_i)
      pop_chk("mem_handshake", mk(K_MEM, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, 2'b00));
    if (done_o)
      pop_chk("done", mk(K_DONE, 1'b0, 4'h0, 32'h0, rdata_o, 2'b00));
    if (err_o)
      pop_chk("error", mk(K_ERR, 1'b0, 4'h0, 32'h0, 32'h0, err_code_o));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    start_i = 1'b1; we_i = w; size_i = s; addr_i = a; wdata_i = d;
  endtask

  int stalls;
  int n;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; we_i = 1'b0; size_i = 2'b00; addr_i = '0; wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", 73'({stall_o, done_o, err_o, err_code_o, mem_req_o, mem_we_o}), 73'(0));
    chk("reset_data", 73'({rdata_o, mem_addr_o}), 73'(0));
    chk("reset_lanes", 73'({mem_be_o, mem_wdata_o}), 73'(0));

    // Store word 0x100, grant on the second REQ cycle
    cyc();
    exp_q.push_back(mk(K_MEM, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 2'b00));
    exp_q.push_back(mk(K_DONE, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00));
    issue(1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
    stalls = 0;
    @(negedge clk); stalls += int'(stall_o);
    cyc(); start_i = 1'b0;
    @(negedge clk); stalls += int'(stall_o);
    cyc(); mem_gnt_i = 1'b1;
    @(negedge clk); stalls += int'(stall_o);
    cyc(); mem_gnt_i = 1'b0;
    @(negedge clk);
    chk("sw_done_stall", 73'({done_o, stall_o}), 73'(2'b10));
    cyc();
    @(negedge clk);
    chk("sw_stall_cycles", 73'(stalls), 73'(3));
    chk("sw_done_pulse", 73'(done_o), 73'(0));

    // Load byte 0x103, grant and rvalid together
    exp_q.push_back(mk(K_MEM, 1'b0, 4'h8, 32'h100, 32'h0, 2'b00));
    exp_q.push_back(mk(K_DONE, 1'b0, 4'h0, 32'h0, 32'h11223344, 2'b00));
    issue(1'b0, 2'b00, 32'h103, 32'h0);
    cyc(); start_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11223344;
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    cyc();

    // Misaligned half load
    exp_q.push_back(mk(K_ERR, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01));
    issue(1'b0, 2'b01, 32'h101, 32'h0);
    @(negedge clk);
    chk("mis_no_stall", 73'(stall_o), 73'(0));
    cyc(); start_i = 1'b0;
    @(negedge clk);
    chk("mis_no_req", 73'({mem_req_o, stall_o}), 73'(0));
    cyc();
    @(negedge clk);
    chk("mis_err_held", 73'({err_o, err_code_o}), 73'(3'b001));

    // Timeout: no grant ever
    exp_q.push_back(mk(K_ERR, 1'b0, 4'h0, 32'h0, 32'h0, 2'b10));
    issue(1'b1, 2'b10, 32'h200, 32'h0);
    cyc(); start_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (mem_req_o && n < 20) begin
      n++;
      cyc();
      @(negedge clk);
    end
    chk("to_req_cycles", 73'(n), 73'(4));
    chk("to_after", 73'({err_o, err_code_o, mem_req_o, stall_o}), 73'(5'b11000));
    cyc();

    // Reset while waiting for rvalid
    exp_q.push_back(mk(K_MEM, 1'b0, 4'hF, 32'h300, 32'h5555AAAA, 2'b00));
    issue(1'b0, 2'b10, 32'h300, 32'h5555AAAA);
    cyc(); start_i = 1'b0; mem_gnt_i = 1'b1;
    cyc(); mem_gnt_i = 1'b0;
    @(negedge clk);
    chk("wait_stall", 73'({stall_o, mem_req_o}), 73'(2'b10));
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_ctrl", 73'({stall_o, done_o, err_o, err_code_o, mem_req_o, mem_we_o}), 73'(0));
    chk("rst_data", 73'({rdata_o, mem_addr_o, mem_be_o}), 73'(0));
    cyc(); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk);
    chk("rst_rvalid_ignored", 73'({done_o, rdata_o}), 73'(0));

    // Store byte 0xAB at 0x102; start during DONE must be ignored
    exp_q.push_back(mk(K_MEM, 1'b1, 4'h4, 32'h100, 32'hABABABAB, 2'b00));
    exp_q.push_back(mk(K_DONE, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00));
    issue(1'b1, 2'b00, 32'h102, 32'h123456AB);
    cyc(); start_i = 1'b0; mem_gnt_i = 1'b1;
    cyc(); mem_gnt_i = 1'b0;
    issue(1'b0, 2'b01, 32'h101, 32'h0);
    cyc(); start_i = 1'b0;
    @(negedge clk);
    chk("done_start_ignored", 73'({err_o, stall_o, mem_req_o}), 73'(0));
    cyc();

    // Store half at 0x102
    exp_q.push_back(mk(K_MEM, 1'b1, 4'hC, 32'h100, 32'hBEEFBEEF, 2'b00));
    exp_q.push_back(mk(K_DONE, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00));
    issue(1'b1, 2'b01, 32'h102, 32'h1234BEEF);
    cyc(); start_i = 1'b0; mem_gnt_i = 1'b1;
    cyc(); mem_gnt_i = 1'b0;
    cyc();

    // Load half 0x002 through WAIT; a grant during WAIT is ignored
    exp_q.push_back(mk(K_MEM, 1'b0, 4'hC, 32'h0, 32'h0, 2'b00));
    exp_q.push_back(mk(K_DONE, 1'b0, 4'h0, 32'h0, 32'hA5A55A5A, 2'b00));
    issue(1'b0, 2'b01, 32'h002, 32'h0);
    cyc(); start_i = 1'b0; mem_gnt_i = 1'b1;
    cyc();
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A55A5A;
    cyc(); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    cyc();

    // Stray rvalid in IDLE leaves rdata_o alone; then illegal size
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    cyc(); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    @(negedge clk);
    chk("idle_rvalid_ignored", 73'({done_o, rdata_o}), 73'({1'b0, 32'hA5A55A5A}));
    exp_q.push_back(mk(K_ERR, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01));
    issue(1'b0, 2'b11, 32'h0, 32'h0);
    cyc(); start_i = 1'b0;
    cyc(); cyc(); cyc();

    chk("scoreboard_drained", 73'(exp_q.size()), 73'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, data-memory address width.
REQ-002 Parameter DATA_W, default 32, data width; fixed at 32 for this core.
REQ-003 Parameter TIMEOUT, default 255, max cycles in REQ+WAIT before abort; range 1..255.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port start_i  in  1  one-cycle request from execution unit; sampled only in IDLE.
REQ-007 Port we_i  in  1  1 = store, 0 = load.
REQ-008 Port size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 Port addr_i  in  ADDR_W  effective address (ALU result).
REQ-010 Port wdata_i  in  DATA_W  store data, unshifted.
REQ-011 Port stall_o  out  1  holds the core pipeline.
REQ-012 Port done_o  out  1  one-cycle completion pulse.
REQ-013 Port rdata_o  out  DATA_W  latched raw load word.
REQ-014 Port err_o  out  1  one-cycle error pulse.
REQ-015 Port err_code_o  out  2  01 misaligned/illegal size, 10 timeout; held until next error.
REQ-016 Port mem_req_o, mem_we_o  out  1 each  memory request and write enable.
REQ-017 Port mem_addr_o  out  ADDR_W  word-aligned address (addr_i with bits [1:0] zeroed).
REQ-018 Port mem_be_o  out  4  byte enables; mem_wdata_o  out  DATA_W  lane-shifted store data.
REQ-019 Port mem_gnt_i, mem_rvalid_i  in  1 each; mem_rdata_i  in  DATA_W.

Function
REQ-020 FSM states IDLE, REQ, WAIT, DONE, encoded in 2 bits.
REQ-021 Misaligned = (size 01 and addr[0]) or (size 10 and addr[1:0]!=0) or size 11.
REQ-022 IDLE + start_i + misaligned: err_o=1 and err_code_o=01 next cycle; no memory request; remain IDLE.
REQ-023 IDLE + start_i + aligned: latch we, addr, be, shifted wdata; go REQ; stall_o=1 combinationally in that same cycle.
REQ-024 mem_be_o: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-025 mem_wdata_o: byte replicated to 4 lanes, half replicated to 2 lanes, word unchanged.
REQ-026 REQ: mem_req_o=1; mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o stable until grant.
REQ-027 REQ + mem_gnt_i + store: go DONE. Load without mem_rvalid_i: go WAIT.
REQ-028 REQ + mem_gnt_i + mem_rvalid_i on a load (same cycle): latch mem_rdata_i; go DONE.
REQ-029 WAIT: mem_req_o=0; on mem_rvalid_i latch mem_rdata_i into rdata_o; go DONE.
REQ-030 DONE: done_o=1 and stall_o=0 for exactly one cycle, then IDLE; start_i ignored.
REQ-031 mem_rvalid_i and mem_gnt_i outside their states are ignored; rdata_o unchanged.
REQ-032 8-bit timeout counter cleared on entering REQ; increments each cycle in REQ or WAIT.
REQ-033 Counter == TIMEOUT with no completion that cycle: err_o=1, err_code_o=10, mem_req_o=0 next cycle, go IDLE; completion wins if same cycle.
REQ-034 stall_o=1 in REQ and WAIT; 0 in IDLE (except REQ-023) and DONE.

Reset
REQ-035 rst_n=0 at a clock edge forces IDLE, clears counter and all outputs to 0 (including rdata_o and err_code_o), regardless of the current state.
REQ-036 Reset mid-transaction drops mem_req_o next cycle; a later mem_rvalid_i is ignored.

Verification
REQ-037 Store word addr 0x100, data 0xDEADBEEF, gnt after 2 cycles -> mem_be_o=1111, stall 3 cycles, done_o pulse, back to IDLE.
REQ-038 Load byte addr 0x103, gnt+rvalid same cycle, rdata 0x11223344 -> mem_be_o=1000, mem_addr_o=0x100, rdata_o=0x11223344, done_o one cycle later.
REQ-039 Load half addr 0x101 -> no mem_req_o, err_o pulse, err_code_o=01, stall_o never asserted.
REQ-040 TIMEOUT=4, gnt never asserted -> err_code_o=10 after 4 REQ cycles, mem_req_o low, IDLE.
REQ-041 rst_n low during WAIT, then rvalid -> outputs zero, rdata_o stays 0, no done_o.
REQ-042 Store byte 0xAB at addr 0x102 -> mem_wdata_o=0xABABABAB, mem_be_o=0100.
